// File: rtl/fwrisc_mem_arb.sv
// fwrisc_mem_arb: arbitrates the core fetch and data ports onto a single memory port
module fwrisc_mem_arb #(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_iaddr,
    input  logic        i_ivalid,
    output logic [31:0] o_idata,
    output logic        o_iready,
    input  logic        i_dvalid,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dwdata,
    input  logic [3:0]  i_dwstb,
    input  logic        i_dwrite,
    output logic [31:0] o_drdata,
    output logic        o_dready,
    output logic [31:0] o_maddr,
    output logic [31:0] o_mwdata,
    output logic [3:0]  o_mwstb,
    output logic        o_mwrite,
    output logic        o_mvalid,
    input  logic [31:0] i_mrdata,
    input  logic        i_mready,
    output logic        o_bus_err
);
    localparam logic [7:0] TIMEOUT_SAT = TIMEOUT_CYCLES > 255 ? 8'd255 : 8'(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_t;
    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstb;
    logic        r_write;
    logic [31:0] r_rdata;
    logic [7:0]  r_wait;
    logic        r_err;
    logic        r_last_d;
    logic        w_mem;
    logic        w_pick_d;
    logic        w_timeout;
    logic        w_done;
    assign w_mem     = r_state == MEM_I || r_state == MEM_D;
    assign w_pick_d  = i_dvalid && (!i_ivalid || DATA_PRIORITY != 0 || !r_last_d);
    assign w_timeout = w_mem && !i_mready && TIMEOUT_SAT != 8'd0 && r_wait == TIMEOUT_SAT - 8'd1;
    assign w_done    = w_mem && (i_mready || w_timeout);
    assign o_maddr   = r_addr;
    assign o_mwdata  = r_wdata;
    assign o_mwstb   = r_wstb;
    assign o_idata   = r_rdata;
    assign o_drdata  = r_rdata;
    // state register
    always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;
    // next state: requests are only sampled in IDLE, so a held request waits one cycle after its ready
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         w_next = (i_ivalid || i_dvalid) ? (w_pick_d ? MEM_D : MEM_I) : IDLE;
            MEM_I, MEM_D: w_next = w_done ? RESP : r_state;
            default:      w_next = IDLE;
        endcase
    end
    // outputs decoded from state; the granted port is the last-grant register
    always_comb begin
        o_mvalid  = w_mem;
        o_mwrite  = r_state == MEM_D && r_write;
        o_iready  = r_state == RESP && !r_last_d;
        o_dready  = r_state == RESP && r_last_d;
        o_bus_err = r_state == RESP && r_err;
    end
    // request capture, wait counting and read-data capture (zero on timeout)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstb   <= '0;
            r_write  <= 1'b0;
            r_rdata  <= '0;
            r_wait   <= '0;
            r_err    <= 1'b0;
            r_last_d <= 1'b0;
        end else begin
            if (r_state == IDLE && (i_ivalid || i_dvalid)) begin
                r_last_d <= w_pick_d;
                r_addr   <= w_pick_d ? i_daddr : i_iaddr;
                r_wdata  <= w_pick_d ? i_dwdata : '0;
                r_wstb   <= w_pick_d ? i_dwstb : '0;
                r_write  <= w_pick_d && i_dwrite;
                r_wait   <= '0;
                r_err    <= 1'b0;
            end
            if (w_mem && !i_mready) r_wait <= r_wait + 8'd1;
            if (w_done) begin
                r_rdata <= i_mready ? i_mrdata : '0;
                r_err   <= w_timeout;
            end
        end
    end
endmodule

// File: doc/fwrisc_mem_arb.md
FWRISC_MEM_ARB -- requirements
Module: fwrisc_mem_arb

Interface
REQ-001 The block SHALL have parameter DATA_PRIORITY, default 1: 1 = data port wins on simultaneous requests, 0 = round-robin.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the number of wait cycles before a transaction is aborted; 0 disables the timeout.
REQ-003 clock  input  1  clock; all logic on posedge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 iaddr  input  32  core fetch address.
REQ-006 ivalid  input  1  core fetch request; held until iready.
REQ-007 idata  output  32  fetch read data; valid while iready=1.
REQ-008 iready  output  1  fetch completion pulse.
REQ-009 dvalid  input  1  core data request; held until dready.
REQ-010 daddr, dwdata  input  32 each  data address and write data.
REQ-011 dwstb  input  4  byte write strobes.
REQ-012 dwrite  input  1  1 = write, 0 = read.
REQ-013 drdata  output  32  data read data; valid while dready=1.
REQ-014 dready  output  1  data completion pulse.
REQ-015 maddr, mwdata  output  32 each  memory address and write data.
REQ-016 mwstb  output  4  memory write strobes.
REQ-017 mwrite  output  1  memory write enable.
REQ-018 mvalid  output  1  memory request.
REQ-019 mrdata  input  32  memory read data.
REQ-020 mready  input  1  memory accept/complete, single cycle.
REQ-021 bus_err  output  1  one-cycle pulse on a timeout abort.

Function
REQ-022 The FSM SHALL have four states: IDLE, MEM_I, MEM_D, RESP.
REQ-023 IDLE SHALL go to MEM_D when only dvalid=1.
REQ-024 IDLE SHALL go to MEM_I when only ivalid=1.
REQ-025 When both requests are set in IDLE: with DATA_PRIORITY=1, MEM_D; with DATA_PRIORITY=0, the port not granted last (first grant after reset goes to data).
REQ-026 On leaving IDLE, the selected port's address, wdata, wstb and write SHALL be registered; the memory outputs SHALL be driven only from these registers.
REQ-027 mvalid SHALL be 1 throughout MEM_I/MEM_D, starting the cycle after the request is sampled (1-cycle request latency).
REQ-028 In MEM_I: mwrite=0 and mwstb=4'h0.
REQ-029 In MEM_I/MEM_D with mready=1: capture mrdata into the read-data register and go to RESP; mvalid SHALL be 0 in RESP.
REQ-030 In RESP, exactly one of iready/dready (the granted port) SHALL be 1 for one cycle; idata and drdata SHALL both show the read-data register. The next state SHALL be IDLE.
REQ-031 Because of REQ-030, a held ivalid/dvalid SHALL never be re-accepted: new requests are sampled only in IDLE, one cycle after the ready pulse.
REQ-032 For a write transaction, the read-data register SHALL still capture mrdata; the core ignores it.
REQ-033 Minimum transaction length: request sampled in cycle N, mvalid in N+1, mready in N+1 gives ready in N+2, next sample in N+3.
REQ-034 Wait counter: 8 bits wide; cleared on entering MEM_*; incremented each MEM_* cycle with mready=0.
REQ-035 When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with mready=0, the block SHALL: load the read-data register with 32'h0, go to RESP, and pulse bus_err in RESP together with the ready.
REQ-036 TIMEOUT_CYCLES values above 255 SHALL saturate to 255.
REQ-037 mready=1 on the timeout cycle SHALL be a normal completion: no bus_err.
REQ-038 mready while not in MEM_* SHALL be ignored.
REQ-039 Input changes during MEM_* SHALL NOT affect the memory outputs (registered per REQ-026).

Reset
REQ-040 On reset=1 at a clock edge, the next cycle SHALL show: state IDLE; mvalid, mwrite, iready, dready, bus_err = 0; maddr, mwdata, idata, drdata = 0; mwstb = 0; wait counter = 0; last-grant = instruction.
REQ-041 Reset mid-transaction SHALL abort it silently: no ready and no bus_err are produced.

Verification
REQ-042 Fetch: ivalid=1, iaddr=32'h100, mready in the first mvalid cycle, mrdata=32'h00000013 -> maddr=32'h100, mwrite=0, iready pulse with idata=32'h13 exactly 2 cycles after the request is sampled.
REQ-043 Conflict: ivalid and dvalid rise together, daddr=32'h2000, dwrite=1, dwdata=32'hCAFEF00D, dwstb=4'hF, DATA_PRIORITY=1 -> the write goes first, then the fetch; exactly one dready and one iready.
REQ-044 Round-robin: DATA_PRIORITY=0, both ports held high for 4 transactions -> grant order D, I, D, I.
REQ-045 Timeout: TIMEOUT_CYCLES=4, mready held at 0 -> mvalid high 4 cycles, then dready with drdata=0 and a one-cycle bus_err pulse.
REQ-046 Reset: assert reset in the second MEM_D cycle -> next cycle mvalid=0, dready=0, state IDLE; a following fetch completes normally.
REQ-047 Wait states: mready asserted after 3 wait cycles, mrdata=32'hA5A5A5A5 -> drdata=32'hA5A5A5A5, no bus_err, maddr stable throughout while daddr is changed.
